// File: rtl/sd_pixel_packer.sv
// SD-card byte stream to SDRAM word packer: strips a per-frame header and buffers payload words.
// Optional macro SD_PIXEL_PACK2_EN packs two payload bytes per 16-bit word.
module sd_pixel_packer #(
  parameter int unsigned FRAME_PIXELS = 307200,
  parameter int unsigned HDR_BYTES    = 54,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [7:0]  IN_DATA,
  input  logic        IN_VALID,
  output logic [15:0] WR_DATA,
  output logic        WR_VALID,
  input  logic        WR_READY,
  output logic        RW_SYNC,
  output logic        FRAME_DONE,
  output logic        OVERFLOW,
  output logic        BUSY
);

  localparam int unsigned CntW = $clog2(FRAME_PIXELS + 1);
  localparam int unsigned HdrW = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned OccW = PtrW + 1;

  localparam logic [CntW-1:0] CntLast = CntW'(FRAME_PIXELS - 1);
  localparam logic [HdrW-1:0] HdrLast = HdrW'((HDR_BYTES > 0) ? HDR_BYTES - 1 : 0);
  localparam logic [OccW-1:0] OccFull = OccW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StHeader, StStream, StFlush} state_e;

  state_e          state_q, state_d;
  logic [HdrW-1:0] hdr_cnt_q, hdr_cnt_d;
  logic [CntW-1:0] byte_cnt_q, byte_cnt_d;
  logic            rw_sync_q, rw_sync_d;
  logic            frame_done_q, frame_done_d;
  logic            overflow_q;
  logic            clr_ovf;
  logic            push;
  logic [15:0]     push_data;

`ifdef SD_PIXEL_PACK2_EN
  logic [7:0]      pack_q, pack_d;
  logic            phase_q, phase_d;
`endif

  logic [15:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [OccW-1:0] occ_q;
  logic            pop, full, push_ok, drop;

  // Frame sequencing and byte-to-word assembly
  always_comb begin
    state_d      = state_q;
    hdr_cnt_d    = hdr_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    rw_sync_d    = 1'b0;
    frame_done_d = 1'b0;
    clr_ovf      = 1'b0;
    push         = 1'b0;
    push_data    = 16'h0000;
`ifdef SD_PIXEL_PACK2_EN
    pack_d       = pack_q;
    phase_d      = phase_q;
`endif
    case (state_q)
      StIdle: begin
        if (START) begin
          clr_ovf    = 1'b1;
          hdr_cnt_d  = '0;
          byte_cnt_d = '0;
`ifdef SD_PIXEL_PACK2_EN
          pack_d     = 8'h00;
          phase_d    = 1'b0;
`endif
          if (HDR_BYTES == 0) begin
            state_d   = StStream;
            rw_sync_d = 1'b1;
          end else begin
            state_d   = StHeader;
          end
        end
      end
      StHeader: begin
        if (IN_VALID) begin
          if (hdr_cnt_q == HdrLast) begin
            state_d    = StStream;
            rw_sync_d  = 1'b1;
            byte_cnt_d = '0;
          end else begin
            hdr_cnt_d  = hdr_cnt_q + HdrW'(1);
          end
        end
      end
      StStream: begin
        if (IN_VALID) begin
          byte_cnt_d = byte_cnt_q + CntW'(1);
`ifdef SD_PIXEL_PACK2_EN
          if (phase_q) begin
            push      = 1'b1;
            push_data = {IN_DATA, pack_q};
            phase_d   = 1'b0;
          end else if (byte_cnt_q == CntLast) begin
            // Odd frame length: the lone final byte goes out zero-extended
            push      = 1'b1;
            push_data = {8'h00, IN_DATA};
          end else begin
            pack_d    = IN_DATA;
            phase_d   = 1'b1;
          end
`else
          push      = 1'b1;
          push_data = {8'h00, IN_DATA};
`endif
          if (byte_cnt_q == CntLast) begin
            frame_done_d = 1'b1;
            state_d      = StFlush;
          end
        end
      end
      StFlush: begin
        if (occ_q == '0) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= StIdle;
      hdr_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      rw_sync_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_cnt_q    <= hdr_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      rw_sync_q    <= rw_sync_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef SD_PIXEL_PACK2_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pack_q  <= 8'h00;
      phase_q <= 1'b0;
    end else begin
      pack_q  <= pack_d;
      phase_q <= phase_d;
    end
  end
`endif

  // Output word buffer; a pop frees a slot for a same-cycle push when full
  assign pop     = (occ_q != '0) && WR_READY;
  assign full    = (occ_q == OccFull);
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({push_ok, pop})
        2'b10:   occ_q <= occ_q + OccW'(1);
        2'b01:   occ_q <= occ_q - OccW'(1);
        default: occ_q <= occ_q;
      endcase
      if (clr_ovf) begin
        overflow_q <= 1'b0;
      end else if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign WR_VALID   = (occ_q != '0);
  assign WR_DATA    = WR_VALID ? mem_q[rd_ptr_q] : 16'h0000;
  assign RW_SYNC    = rw_sync_q;
  assign FRAME_DONE = frame_done_q;
  assign OVERFLOW   = overflow_q;
  assign BUSY       = (state_q != StIdle);

endmodule

// File: tb/tb_sd_pixel_packer.sv
// Directed bench for sd_pixel_packer; two instances share stimulus and are checked per scenario.
module tb_sd_pixel_packer;

`ifdef SD_PIXEL_PACK2_EN
  localparam int unsigned BPixels = 5;
`else
  localparam int unsigned BPixels = 6;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        wr_ready;

  logic [15:0] a_wr_data, b_wr_data;
  logic        a_wr_valid, a_rw_sync, a_frame_done, a_overflow, a_busy;
  logic        b_wr_valid, b_rw_sync, b_frame_done, b_overflow, b_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sd_pixel_packer #(.FRAME_PIXELS(4), .HDR_BYTES(2), .FIFO_DEPTH(4)) u_dut_a (
    .CLK(clk), .RESET(rst), .START(start), .IN_DATA(in_data), .IN_VALID(in_valid),
    .WR_DATA(a_wr_data), .WR_VALID(a_wr_valid), .WR_READY(wr_ready), .RW_SYNC(a_rw_sync),
    .FRAME_DONE(a_frame_done), .OVERFLOW(a_overflow), .BUSY(a_busy)
  );

  sd_pixel_packer #(.FRAME_PIXELS(BPixels), .HDR_BYTES(0), .FIFO_DEPTH(4)) u_dut_b (
    .CLK(clk), .RESET(rst), .START(start), .IN_DATA(in_data), .IN_VALID(in_valid),
    .WR_DATA(b_wr_data), .WR_VALID(b_wr_valid), .WR_READY(wr_ready), .RW_SYNC(b_rw_sync),
    .FRAME_DONE(b_frame_done), .OVERFLOW(b_overflow), .BUSY(b_busy)
  );

  typedef struct {
    logic        start;
    logic        valid;
    logic [7:0]  data;
    logic        ready;
    logic        ev;
    logic [15:0] ed;
    logic        es;
    logic        efd;
    logic        eb;
  } vec_t;

  vec_t tbl [9];

  function automatic vec_t mk(logic s, logic v, logic [7:0] d, logic r, logic ev,
                              logic [15:0] ed, logic es, logic efd, logic eb);
    vec_t t;
    t.start = s; t.valid = v; t.data = d; t.ready = r;
    t.ev = ev; t.ed = ed; t.es = es; t.efd = efd; t.eb = eb;
    return t;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs and land 1 ns after the rising edge.
  task automatic drive(input logic s, input logic v, input logic [7:0] d, input logic r);
    start = s; in_valid = v; in_data = d; wr_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    rst = 1'b0;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].start, tbl[i].valid, tbl[i].data, tbl[i].ready);
      chk($sformatf("%s[%0d] wr_valid", tag, i), {15'b0, a_wr_valid}, {15'b0, tbl[i].ev});
      chk($sformatf("%s[%0d] wr_data", tag, i), a_wr_data, tbl[i].ed);
      chk($sformatf("%s[%0d] rw_sync", tag, i), {15'b0, a_rw_sync}, {15'b0, tbl[i].es});
      chk($sformatf("%s[%0d] frame_done", tag, i), {15'b0, a_frame_done}, {15'b0, tbl[i].efd});
      chk($sformatf("%s[%0d] busy", tag, i), {15'b0, a_busy}, {15'b0, tbl[i].eb});
      chk($sformatf("%s[%0d] overflow", tag, i), {15'b0, a_overflow}, 16'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    start = 1'b0; in_valid = 1'b0; in_data = 8'h00; wr_ready = 1'b0; rst = 1'b0;

    tbl[0] = mk(1, 0, 8'h00, 1, 0, 16'h0000, 0, 0, 1);
    tbl[1] = mk(0, 1, 8'hAA, 1, 0, 16'h0000, 0, 0, 1);
    tbl[2] = mk(0, 1, 8'hBB, 1, 0, 16'h0000, 1, 0, 1);
`ifdef SD_PIXEL_PACK2_EN
    tbl[3] = mk(0, 1, 8'h01, 1, 0, 16'h0000, 0, 0, 1);
    tbl[4] = mk(0, 1, 8'h02, 1, 1, 16'h0201, 0, 0, 1);
    tbl[5] = mk(0, 1, 8'h03, 1, 0, 16'h0000, 0, 0, 1);
    tbl[6] = mk(0, 1, 8'h04, 1, 1, 16'h0403, 0, 1, 1);
`else
    tbl[3] = mk(0, 1, 8'h01, 1, 1, 16'h0001, 0, 0, 1);
    tbl[4] = mk(0, 1, 8'h02, 1, 1, 16'h0002, 0, 0, 1);
    tbl[5] = mk(0, 1, 8'h03, 1, 1, 16'h0003, 0, 0, 1);
    tbl[6] = mk(0, 1, 8'h04, 1, 1, 16'h0004, 0, 1, 1);
`endif
    tbl[7] = mk(0, 0, 8'h00, 1, 0, 16'h0000, 0, 0, 1);
    tbl[8] = mk(0, 0, 8'h00, 1, 0, 16'h0000, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk("reset wr_valid", {15'b0, a_wr_valid}, 16'h0);
    chk("reset wr_data", a_wr_data, 16'h0000);
    chk("reset rw_sync", {15'b0, a_rw_sync}, 16'h0);
    chk("reset frame_done", {15'b0, a_frame_done}, 16'h0);
    chk("reset overflow", {15'b0, a_overflow}, 16'h0);
    chk("reset busy", {15'b0, a_busy}, 16'h0);

    run_table("frame");

    // Reset mid-frame with words still buffered, then a clean frame.
    do_reset();
    drive(1, 0, 8'h00, 0);
    drive(0, 1, 8'hAA, 0);
    drive(0, 1, 8'hBB, 0);
    drive(0, 1, 8'h01, 0);
    drive(0, 1, 8'h02, 0);
    drive(0, 1, 8'h03, 0);
    chk("midrst pre wr_valid", {15'b0, a_wr_valid}, 16'h1);
`ifdef SD_PIXEL_PACK2_EN
    chk("midrst pre wr_data", a_wr_data, 16'h0201);
`else
    chk("midrst pre wr_data", a_wr_data, 16'h0001);
`endif
    rst = 1'b1;
    drive(0, 0, 8'h00, 0);
    rst = 1'b0;
    chk("midrst wr_valid", {15'b0, a_wr_valid}, 16'h0);
    chk("midrst wr_data", a_wr_data, 16'h0000);
    chk("midrst frame_done", {15'b0, a_frame_done}, 16'h0);
    chk("midrst busy", {15'b0, a_busy}, 16'h0);
    drive(0, 0, 8'h00, 0);
    chk("midrst idle frame_done", {15'b0, a_frame_done}, 16'h0);
    run_table("after_rst");

    // START while streaming must not disturb the byte count.
    do_reset();
    drive(1, 0, 8'h00, 1);
    drive(0, 1, 8'hAA, 1);
    drive(0, 1, 8'hBB, 1);
    drive(0, 1, 8'h01, 1);
    drive(1, 1, 8'h02, 1);
    chk("restart busy", {15'b0, a_busy}, 16'h1);
    chk("restart rw_sync", {15'b0, a_rw_sync}, 16'h0);
    chk("restart frame_done b2", {15'b0, a_frame_done}, 16'h0);
    drive(0, 1, 8'h03, 1);
    chk("restart frame_done b3", {15'b0, a_frame_done}, 16'h0);
    drive(0, 1, 8'h04, 1);
    chk("restart frame_done b4", {15'b0, a_frame_done}, 16'h1);
    drive(0, 0, 8'h00, 1);
    drive(0, 0, 8'h00, 1);
    chk("restart busy end", {15'b0, a_busy}, 16'h0);

`ifdef SD_PIXEL_PACK2_EN
    // Packed odd-length frame with no header: 2211 4433 0055.
    do_reset();
    drive(1, 0, 8'h00, 1);
    chk("pack rw_sync", {15'b0, b_rw_sync}, 16'h1);
    chk("pack busy", {15'b0, b_busy}, 16'h1);
    drive(0, 1, 8'h11, 1);
    chk("pack b1 wr_valid", {15'b0, b_wr_valid}, 16'h0);
    drive(0, 1, 8'h22, 1);
    chk("pack w0", b_wr_data, 16'h2211);
    drive(0, 1, 8'h33, 1);
    chk("pack b3 wr_valid", {15'b0, b_wr_valid}, 16'h0);
    drive(0, 1, 8'h44, 1);
    chk("pack w1", b_wr_data, 16'h4433);
    drive(0, 1, 8'h55, 1);
    chk("pack w2", b_wr_data, 16'h0055);
    chk("pack frame_done", {15'b0, b_frame_done}, 16'h1);
    drive(0, 0, 8'h00, 1);
    chk("pack drained", {15'b0, b_wr_valid}, 16'h0);
    chk("pack frame_done end", {15'b0, b_frame_done}, 16'h0);
    drive(0, 0, 8'h00, 1);
    chk("pack idle", {15'b0, b_busy}, 16'h0);
`else
    // Sink stalled: four words held, two dropped, head word stable.
    do_reset();
    drive(1, 0, 8'h00, 0);
    chk("ovf rw_sync", {15'b0, b_rw_sync}, 16'h1);
    for (int i = 1; i <= 4; i++) begin
      drive(0, 1, 8'(i), 0);
      chk($sformatf("ovf fill%0d wr_data", i), b_wr_data, 16'h0001);
    end
    chk("ovf not yet", {15'b0, b_overflow}, 16'h0);
    drive(0, 1, 8'h05, 0);
    chk("ovf set", {15'b0, b_overflow}, 16'h1);
    chk("ovf head stable", b_wr_data, 16'h0001);
    drive(0, 1, 8'h06, 0);
    chk("ovf frame_done", {15'b0, b_frame_done}, 16'h1);
    chk("ovf head stable2", b_wr_data, 16'h0001);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 8'h00, 1);
      chk($sformatf("ovf drain%0d wr_valid", k), {15'b0, b_wr_valid}, (k < 3) ? 16'h1 : 16'h0);
      chk($sformatf("ovf drain%0d wr_data", k), b_wr_data, (k < 3) ? 16'(2 + k) : 16'h0000);
    end
    drive(0, 0, 8'h00, 1);
    chk("ovf idle", {15'b0, b_busy}, 16'h0);
    chk("ovf sticky", {15'b0, b_overflow}, 16'h1);

    // Push and pop together while full: nothing dropped, occupancy kept.
    drive(1, 0, 8'h00, 0);
    chk("full start clears ovf", {15'b0, b_overflow}, 16'h0);
    for (int i = 1; i <= 4; i++) begin
      drive(0, 1, 8'(i), 0);
    end
    drive(0, 1, 8'h05, 1);
    chk("full pp overflow", {15'b0, b_overflow}, 16'h0);
    chk("full pp head", b_wr_data, 16'h0002);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 8'h00, 1);
      chk($sformatf("full drain%0d wr_valid", k), {15'b0, b_wr_valid}, (k < 3) ? 16'h1 : 16'h0);
      chk($sformatf("full drain%0d wr_data", k), b_wr_data, (k < 3) ? 16'(3 + k) : 16'h0000);
    end
    chk("full overflow end", {15'b0, b_overflow}, 16'h0);
`endif

    do_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_pixel_packer.md
SD_PIXEL_PACKER -- requirements
Module: sd_pixel_packer

Interface
REQ-001 SHALL have parameter FRAME_PIXELS, default 307200, payload bytes per frame (640x480 grey).
REQ-002 SHALL have parameter HDR_BYTES, default 54, leading bytes discarded per frame (BMP header); 0 is legal.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output word buffer entries, a power of 2, at least 2.
REQ-004 SHALL have port CLK  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port RESET  in  1  synchronous, active-high reset.
REQ-006 SHALL have port START  in  1  one-cycle pulse that arms a new frame.
REQ-007 SHALL have port IN_DATA  in  8  byte from the SPI/SD host.
REQ-008 SHALL have port IN_VALID  in  1  IN_DATA valid this cycle; there is no backpressure to the source.
REQ-009 SHALL have port WR_DATA  out  16  word to the SDRAM write FIFO.
REQ-010 SHALL have port WR_VALID  out  1  WR_DATA valid, asserted while the buffer is non-empty.
REQ-011 SHALL have port WR_READY  in  1  sink accepts the word when WR_VALID and WR_READY are both high.
REQ-012 SHALL have port RW_SYNC  out  1  one-cycle pulse at frame payload start, for write-address reset.
REQ-013 SHALL have port FRAME_DONE  out  1  one-cycle pulse when the last payload word has been pushed.
REQ-014 SHALL have port OVERFLOW  out  1  sticky flag, a word was dropped because the buffer was full.
REQ-015 SHALL have port BUSY  out  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement the FSM states IDLE, HEADER, STREAM and FLUSH.
REQ-017 SHALL go IDLE->HEADER on START, or IDLE->STREAM on START if HDR_BYTES==0; START outside IDLE is ignored.
REQ-018 HEADER SHALL count IN_VALID bytes, discard them, and enter STREAM after byte HDR_BYTES.
REQ-019 SHALL pulse RW_SYNC for exactly one cycle on the transition into STREAM.
REQ-020 STREAM SHALL count accepted payload bytes in a counter of width clog2(FRAME_PIXELS+1); the counter starts at 0 on entering STREAM.
REQ-021 SHALL, when the byte counter reaches FRAME_PIXELS, push any partial word, pulse FRAME_DONE, and go STREAM->FLUSH.
REQ-022 FLUSH SHALL wait for an empty buffer and then go to IDLE; bytes arriving in FLUSH or IDLE are discarded.
REQ-023 SHALL make a word pushed in cycle N visible as WR_VALID=1 in cycle N+1 when the buffer was empty.
REQ-024 SHALL drop a word pushed while the buffer is full and pop does not occur in the same cycle, and set OVERFLOW.
REQ-025 SHALL honour a simultaneous push and pop when full; no drop occurs and the count is unchanged.
REQ-026 SHALL hold WR_DATA stable while WR_VALID=1 and WR_READY=0.
REQ-027 SHALL use buffer pointers that wrap modulo FIFO_DEPTH, with an occupancy counter of width clog2(FIFO_DEPTH)+1.

Reset
REQ-028 RESET SHALL force IDLE, an empty buffer, cleared counters, and a cleared pack register.
REQ-029 RESET SHALL drive WR_VALID=0, RW_SYNC=0, FRAME_DONE=0, OVERFLOW=0, BUSY=0 and WR_DATA=16'h0000.
REQ-030 RESET mid-frame SHALL abandon the frame with no FRAME_DONE; buffered words are discarded.
REQ-031 START SHALL also clear OVERFLOW.

Configuration
REQ-032 SHALL use macro SD_PIXEL_PACK2_EN.
REQ-033 With SD_PIXEL_PACK2_EN defined, two bytes SHALL form one word {second, first}, pushed when the second byte arrives.
REQ-034 With SD_PIXEL_PACK2_EN defined and odd FRAME_PIXELS, the final word SHALL be {8'h00, last}.
REQ-035 Without SD_PIXEL_PACK2_EN, every payload byte SHALL be pushed as {8'h00, byte} in its arrival cycle.

Verification
REQ-036 Bench SHALL cover: HDR_BYTES=2, FRAME_PIXELS=4, no pack, WR_READY=1, bytes AA BB 01 02 03 04 -> RW_SYNC pulse after BB; words 0001 0002 0003 0004; FRAME_DONE with 0004 push; BUSY then 0.
REQ-037 Bench SHALL cover: pack enabled, FRAME_PIXELS=5, HDR_BYTES=0, bytes 11 22 33 44 55 -> words 2211 4433 0055, then IDLE.
REQ-038 Bench SHALL cover: FIFO_DEPTH=4, WR_READY=0, 6 payload bytes, no pack -> 4 words held, OVERFLOW=1, WR_DATA stays 0001.
REQ-039 Bench SHALL cover: buffer full, push and pop in the same cycle -> occupancy stays 4 and OVERFLOW stays 0.
REQ-040 Bench SHALL cover: RESET after 3 payload bytes -> WR_VALID=0 next cycle, no FRAME_DONE, and a new START runs a clean frame.
REQ-041 Bench SHALL cover: START during STREAM -> ignored, byte count unaffected.
